// File: rtl/tdm_demux4_pkg.sv
// rtl/tdm_demux4_pkg.sv - shared constants and types for the 4-slot TDM demultiplexer
// Purpose : frame geometry (slot count, slot index width) and FSM state encodings
//           used by tdm_demux4 and its decoder.
// Ports   : none (package).
package tdm_demux4_pkg;

  localparam int TDM_SLOTS = 4;
  localparam int SLOT_W    = 2;

  // HUNT: waiting for a sync marker. LOCKED: frame alignment established.
  typedef enum logic {
    TDM_HUNT   = 1'b0,
    TDM_LOCKED = 1'b1
  } tdm_state_e;

endpackage

// File: rtl/tdm_demux4_demux1x4_en.sv
// rtl/tdm_demux4_demux1x4_en.sv - combinational 1-to-4 decoder with enable
// Purpose : turns a slot index plus a capture-enable into four one-hot write
//           enables; these drive both the channel register loads and the
//           per-channel update strobes, so at most one channel is ever touched.
// Ports   : sel_i  slot index (SLOT_W bits)
//           en_i   capture enable
//           we_o   one-hot write enables, bit k selects channel k (all 0 when en_i=0)
module demux1x4_en
  import tdm_demux4_pkg::*;
(
  input  logic [SLOT_W-1:0]    sel_i,
  input  logic                 en_i,
  output logic [TDM_SLOTS-1:0] we_o
);

  always_comb begin
    we_o = '0;
    if (en_i) begin
      we_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - receive-side 4-slot time-division demultiplexer
// Purpose : samples din on every en cycle, aligns to frames using the sync
//           marker (slot 0), and steers each sample into one of four
//           registered channel outputs with one-cycle latency.
// Config  : TDM_DEMUX_PARITY_EN adds input par (even parity over din) and a
//           registered perr strobe raised alongside v* for a captured sample
//           whose ^{din,par} is 1.
// Ports   : clk, rst      clock, synchronous active-high reset
//           en            sample valid; din/sync/par ignored when low
//           sync          current din is slot 0 of a frame
//           din           serial sample (WIDTH bits)
//           y0..y3        channel outputs, hold last captured value
//           v0..v3        one-cycle strobe: matching y updated
//           frame         one-cycle strobe: slot 3 of an aligned frame captured
//           slot          next slot index to be filled
//           locked        high while frame alignment is held
//           err           one-cycle strobe: alignment error
//           par, perr     parity input / parity error strobe (parity build only)
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             v0,
  output logic             v1,
  output logic             v2,
  output logic             v3,
  output logic             frame,
  output logic [1:0]       slot,
  output logic             locked,
  output logic             err
`ifdef TDM_DEMUX_PARITY_EN
  ,
  input  logic             par,
  output logic             perr
`endif
);

  tdm_state_e              state_q, state_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [WIDTH-1:0]        y0_q, y1_q, y2_q, y3_q;
  logic [TDM_SLOTS-1:0]    v_q;
  logic                    frame_q, frame_d;
  logic                    err_q, err_d;

  // Capture request: which slot to write and whether to write at all.
  logic                    cap_en;
  logic [SLOT_W-1:0]       cap_sel;
  logic [TDM_SLOTS-1:0]    we;

  demux1x4_en u_dec (
    .sel_i (cap_sel),
    .en_i  (cap_en),
    .we_o  (we)
  );

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cap_en  = 1'b0;
    cap_sel = '0;
    frame_d = 1'b0;
    err_d   = 1'b0;

    if (en) begin
      case (state_q)
        TDM_HUNT: begin
          // Samples before the first sync are dropped silently.
          if (sync) begin
            cap_en  = 1'b1;
            cap_sel = '0;
            slot_d  = SLOT_W'(1);
            state_d = TDM_LOCKED;
          end
        end

        TDM_LOCKED: begin
          if (sync) begin
            // Sync always restarts the frame; arriving anywhere but slot 0
            // means we lost alignment, but the new frame is taken as valid.
            err_d   = (slot_q != '0);
            cap_en  = 1'b1;
            cap_sel = '0;
            slot_d  = SLOT_W'(1);
          end else if (slot_q == '0) begin
            // Expected a sync marker and did not see one: drop lock.
            err_d   = 1'b1;
            slot_d  = '0;
            state_d = TDM_HUNT;
          end else begin
            cap_en  = 1'b1;
            cap_sel = slot_q;
            if (slot_q == SLOT_W'(TDM_SLOTS - 1)) begin
              frame_d = 1'b1;
              slot_d  = '0;
            end else begin
              slot_d  = slot_q + SLOT_W'(1);
            end
          end
        end

        default: begin
          state_d = TDM_HUNT;
          slot_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TDM_HUNT;
      slot_q  <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      y3_q    <= '0;
      v_q     <= '0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      v_q     <= we;
      frame_q <= frame_d;
      err_q   <= err_d;
      if (we[0]) y0_q <= din;
      if (we[1]) y1_q <= din;
      if (we[2]) y2_q <= din;
      if (we[3]) y3_q <= din;
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  logic perr_q;

  // Only captured samples are checked, so perr always coincides with a v*.
  always_ff @(posedge clk) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= cap_en & (^{din, par});
    end
  end

  assign perr = perr_q;
`endif

  assign y0     = y0_q;
  assign y1     = y1_q;
  assign y2     = y2_q;
  assign y3     = y3_q;
  assign v0     = v_q[0];
  assign v1     = v_q[1];
  assign v2     = v_q[2];
  assign v3     = v_q[3];
  assign frame  = frame_q;
  assign err    = err_q;
  assign slot   = slot_q;
  assign locked = (state_q == TDM_LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - self-checking bench for tdm_demux4 (WIDTH=4)
module tb_tdm_demux4;

  logic       clk;
  logic       rst;
  logic       en;
  logic       sync;
  logic [3:0] din;
  logic [3:0] y0, y1, y2, y3;
  logic       v0, v1, v2, v3;
  logic       frame;
  logic [1:0] slot;
  logic       locked;
  logic       err;
  logic       par;
  logic       perr;

  int checks   = 0;
  int failures = 0;

  tdm_demux4 #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .sync   (sync),
    .din    (din),
    .y0     (y0),
    .y1     (y1),
    .y2     (y2),
    .y3     (y3),
    .v0     (v0),
    .v1     (v1),
    .v2     (v2),
    .v3     (v3),
    .frame  (frame),
    .slot   (slot),
    .locked (locked),
    .err    (err)
`ifdef TDM_DEMUX_PARITY_EN
    ,
    .par    (par),
    .perr   (perr)
`endif
  );

`ifndef TDM_DEMUX_PARITY_EN
  assign perr = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       sync;
    logic [3:0] din;
    logic       par;
    logic [3:0] ey0, ey1, ey2, ey3;
    logic [3:0] ev;
    logic       eframe;
    logic [1:0] eslot;
    logic       elocked;
    logic       eerr;
    logic       eperr;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(logic r, logic e, logic s, logic [3:0] d, logic p,
                              logic [3:0] a0, logic [3:0] a1, logic [3:0] a2, logic [3:0] a3,
                              logic [3:0] v, logic f, logic [1:0] sl, logic lk,
                              logic er, logic pe);
    vec_t t;
    t.rst = r; t.en = e; t.sync = s; t.din = d; t.par = p;
    t.ey0 = a0; t.ey1 = a1; t.ey2 = a2; t.ey3 = a3;
    t.ev = v; t.eframe = f; t.eslot = sl; t.elocked = lk; t.eerr = er; t.eperr = pe;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic compare_outputs(input string tag);
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard_empty actual=0 expected=1", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".y0"}, y0, e.ey0);
      chk({tag, ".y1"}, y1, e.ey1);
      chk({tag, ".y2"}, y2, e.ey2);
      chk({tag, ".y3"}, y3, e.ey3);
      chk({tag, ".v"}, {v3, v2, v1, v0}, e.ev);
      chk({tag, ".frame"}, frame, e.eframe);
      chk({tag, ".slot"}, slot, e.eslot);
      chk({tag, ".locked"}, locked, e.elocked);
      chk({tag, ".err"}, err, e.eerr);
`ifdef TDM_DEMUX_PARITY_EN
      chk({tag, ".perr"}, perr, e.eperr);
`endif
    end
  endtask

  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    rst  = t.rst;
    en   = t.en;
    sync = t.sync;
    din  = t.din;
    par  = t.par;
    exp_q.push_back(t);
    @(posedge clk);
    #1;
    compare_outputs(tag);
  endtask

  initial begin
    int cyc;
    bit seen;
    rst = 1'b1; en = 1'b0; sync = 1'b0; din = 4'h0; par = 1'b0;

    //          rst en sy din par  y0  y1  y2  y3   v      fr sl lk er pe
    vecs.push_back(mk(1, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 0, 0, 0, 0, 0));
    // HUNT: no sync, samples dropped
    vecs.push_back(mk(0, 1, 0, 4'hF, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'hF, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'hF, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 0, 0, 0, 0, 0));
    // first frame 1,0,1,0
    vecs.push_back(mk(0, 1, 1, 4'h1, 1, 4'h1, 4'h0, 4'h0, 4'h0, 4'b0001, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'h0, 0, 4'h1, 4'h0, 4'h0, 4'h0, 4'b0010, 0, 2, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'h1, 1, 4'h1, 4'h0, 4'h1, 4'h0, 4'b0100, 0, 3, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'h0, 0, 4'h1, 4'h0, 4'h1, 4'h0, 4'b1000, 1, 0, 1, 0, 0));
    // en toggling, 5,6,7,8 with idle cycles in between
    vecs.push_back(mk(0, 1, 1, 4'h5, 0, 4'h5, 4'h0, 4'h1, 4'h0, 4'b0001, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'hF, 1, 4'h5, 4'h0, 4'h1, 4'h0, 4'b0000, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'h6, 0, 4'h5, 4'h6, 4'h1, 4'h0, 4'b0010, 0, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 4'hF, 0, 4'h5, 4'h6, 4'h1, 4'h0, 4'b0000, 0, 2, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'h7, 1, 4'h5, 4'h6, 4'h7, 4'h0, 4'b0100, 0, 3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'hF, 0, 4'h5, 4'h6, 4'h7, 4'h0, 4'b0000, 0, 3, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'h8, 1, 4'h5, 4'h6, 4'h7, 4'h8, 4'b1000, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'hF, 0, 4'h5, 4'h6, 4'h7, 4'h8, 4'b0000, 0, 0, 1, 0, 0));
    // early sync at slot 2
    vecs.push_back(mk(0, 1, 1, 4'h1, 1, 4'h1, 4'h6, 4'h7, 4'h8, 4'b0001, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'h2, 1, 4'h1, 4'h2, 4'h7, 4'h8, 4'b0010, 0, 2, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'h9, 0, 4'h9, 4'h2, 4'h7, 4'h8, 4'b0001, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 4'hA, 0, 4'h9, 4'hA, 4'h7, 4'h8, 4'b0010, 0, 2, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'hB, 1, 4'h9, 4'hA, 4'hB, 4'h8, 4'b0100, 0, 3, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'hC, 0, 4'h9, 4'hA, 4'hB, 4'hC, 4'b1000, 1, 0, 1, 0, 0));
    // missing sync at slot 0: lose lock, then stay in HUNT until sync
    vecs.push_back(mk(0, 1, 0, 4'h3, 1, 4'h9, 4'hA, 4'hB, 4'hC, 4'b0000, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 4'h4, 0, 4'h9, 4'hA, 4'hB, 4'hC, 4'b0000, 0, 0, 0, 0, 0));
    // relock; parity-bad then parity-good sample of 4'b0111
    vecs.push_back(mk(0, 1, 1, 4'h7, 0, 4'h7, 4'hA, 4'hB, 4'hC, 4'b0001, 0, 1, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 4'h7, 1, 4'h7, 4'h7, 4'hB, 4'hC, 4'b0010, 0, 2, 1, 0, 0));
    // reset mid-frame: sample lost, everything cleared
    vecs.push_back(mk(1, 1, 0, 4'hE, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'hE, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back frame: frame must pulse within a bounded window, exactly 4 samples in.
    @(negedge clk);
    en = 1'b1; sync = 1'b1; din = 4'h3; par = 1'b0;
    @(negedge clk);
    sync = 1'b0; din = 4'h4; par = 1'b1;
    @(negedge clk);
    din = 4'h5; par = 1'b0;
    @(negedge clk);
    din = 4'h6; par = 1'b0;
    @(posedge clk);
    #1;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 8) begin
      if (frame) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    en = 1'b0;
    chk("b2b.frame_seen", seen, 1);
    chk("b2b.frame_delay", cyc, 0);
    chk("b2b.ys", {y0, y1, y2, y3}, 16'h3456);
    chk("b2b.slot", slot, 0);
    @(posedge clk);
    #1;
    chk("b2b.frame_once", frame, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
